onp_tokenizer: RTL and testbench

- Upstream front-end for the `onp` RPN stack core.
- Accepts an ASCII character stream over a valid/ready handshake and accumulates decimal literals.
- Translates each token into a `step`/`push`/`d`/`op` command for the core.
- Monitors the core's `cnt` to block illegal commands, and captures the core's top-of-stack as the result on `=` or newline.

---
 rtl/onp_pkg.sv | 42 ++++
 rtl/char_class.sv | 32 +++
 rtl/onp_tokenizer.sv | 192 +++++++++++++++++++
 tb/tb_onp_tokenizer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/onp_pkg.sv
// Shared types and constants for the onp tokenizer front-end.
package onp_pkg;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    NEG = 2'd1,
    ADD = 2'd2,
    MUL = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NUM,
    S_CHECK,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_FIN
  } state_t;

  typedef enum logic [2:0] {
    K_DIGIT,
    K_DELIM,
    K_OP,
    K_END,
    K_BAD
  } kind_t;

  localparam int unsigned ERR_BAD   = 0;
  localparam int unsigned ERR_UNDER = 1;
  localparam int unsigned ERR_OVER  = 2;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_TILDE = 8'h7E;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_LF    = 8'h0A;

endpackage

// File: rtl/char_class.sv
// Combinational ASCII decoder: character -> token kind, digit value, operator.
module char_class
  import onp_pkg::*;
(
  input  logic [7:0] ch,
  output kind_t      kind,
  output logic [3:0] digit,
  output op_t        op
);

  // Classify one character; everything unrecognised is K_BAD.
  always_comb begin
    kind  = K_BAD;
    digit = '0;
    op    = NOP;
    if (ch >= CH_0 && ch <= CH_9) begin
      kind  = K_DIGIT;
      digit = ch[3:0];
    end else begin
      case (ch)
        CH_SP:    kind = K_DELIM;
        CH_PLUS:  begin kind = K_OP; op = ADD; end
        CH_STAR:  begin kind = K_OP; op = MUL; end
        CH_TILDE: begin kind = K_OP; op = NEG; end
        CH_EQ,
        CH_LF:    kind = K_END;
        default:  kind = K_BAD;
      endcase
    end
  end

endmodule

// File: rtl/onp_tokenizer.sv
// Character-stream front-end for the onp RPN core: accumulates literals,
// issues push/op commands with a setup/strobe/hold handshake, guards against
// stack under/overflow and captures the final top-of-stack.
module onp_tokenizer
  import onp_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 10,
  parameter int unsigned DEPTH = 1024
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             step,
  output logic             push,
  output logic [W-1:0]     d,
  output logic [1:0]       op,
  input  logic [CNT_W-1:0] cnt,
  input  logic [W-1:0]     top,
  output logic [W-1:0]     result,
  output logic             result_valid,
  output logic [2:0]       err
);

  localparam logic [CNT_W-1:0] PUSH_LIM = CNT_W'(DEPTH - 1);

  kind_t      c_kind;
  logic [3:0] c_digit;
  op_t        c_op;

  char_class u_class (
    .ch    (in_data),
    .kind  (c_kind),
    .digit (c_digit),
    .op    (c_op)
  );

  state_t       state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic         pend_push_q, pend_push_d;
  logic         pend_op_v_q, pend_op_v_d;
  op_t          pend_op_q, pend_op_d;
  logic         pend_end_q, pend_end_d;
  logic         in_ready_q, in_ready_d;
  logic         step_q, step_d;
  logic         push_q, push_d;
  logic [W-1:0] d_q, d_d;
  op_t          op_q, op_d;
  logic [W-1:0] result_q, result_d;
  logic         result_valid_q, result_valid_d;
  logic [2:0]   err_q, err_d;

  logic         fire;
  logic [W-1:0] digit_ext;
  state_t       after_cmd;

  assign fire      = in_valid && in_ready_q;
  assign digit_ext = {{(W-4){1'b0}}, c_digit};

  // Next-state, accumulator and command-register logic.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    pend_push_d    = pend_push_q;
    pend_op_v_d    = pend_op_v_q;
    pend_op_d      = pend_op_q;
    pend_end_d     = pend_end_q;
    push_d         = push_q;
    d_d            = d_q;
    op_d           = op_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    err_d          = err_q;
    // Where to go once the current command is finished or dropped.
    after_cmd = pend_op_v_q ? S_CHECK : (pend_end_q ? S_FIN : S_IDLE);

    case (state_q)
      S_IDLE: if (fire) begin
        case (c_kind)
          K_DIGIT: begin acc_d = digit_ext; state_d = S_NUM; end
          K_OP:    begin pend_op_v_d = 1'b1; pend_op_d = c_op; state_d = S_CHECK; end
          K_END:   state_d = S_FIN;
          K_BAD:   err_d[ERR_BAD] = 1'b1;
          default: ;
        endcase
      end
      S_NUM: if (fire) begin
        case (c_kind)
          K_DIGIT: acc_d = acc_q * W'(10) + digit_ext;
          K_DELIM: begin pend_push_d = 1'b1; state_d = S_CHECK; end
          K_OP: begin
            pend_push_d = 1'b1;
            pend_op_v_d = 1'b1;
            pend_op_d   = c_op;
            state_d     = S_CHECK;
          end
          K_END:   begin pend_push_d = 1'b1; pend_end_d = 1'b1; state_d = S_CHECK; end
          default: begin err_d[ERR_BAD] = 1'b1; acc_d = '0; state_d = S_IDLE; end
        endcase
      end
      // Pending actions are served push first, then op, then end.
      S_CHECK: begin
        if (pend_push_q) begin
          pend_push_d = 1'b0;
          if (cnt < PUSH_LIM) begin
            push_d  = 1'b1;
            d_d     = acc_q;
            op_d    = NOP;
            state_d = S_SETUP;
          end else begin
            err_d[ERR_OVER] = 1'b1;
            state_d         = after_cmd;
          end
        end else if (pend_op_v_q) begin
          pend_op_v_d = 1'b0;
          if ((pend_op_q == NEG) ? (cnt >= CNT_W'(1)) : (cnt >= CNT_W'(2))) begin
            push_d  = 1'b0;
            op_d    = pend_op_q;
            state_d = S_SETUP;
          end else begin
            err_d[ERR_UNDER] = 1'b1;
            state_d          = pend_end_q ? S_FIN : S_IDLE;
          end
        end else begin
          state_d = pend_end_q ? S_FIN : S_IDLE;
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: state_d = S_HOLD;
      S_HOLD:   state_d = after_cmd;
      S_FIN: begin
        result_d       = top;
        result_valid_d = 1'b1;
        if (cnt != CNT_W'(1)) err_d[ERR_UNDER] = 1'b1;
        pend_end_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs follow the state being entered.
    step_d     = (state_d == S_STROBE);
    in_ready_d = (state_d == S_IDLE) || (state_d == S_NUM);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= S_IDLE;
      acc_q          <= '0;
      pend_push_q    <= 1'b0;
      pend_op_v_q    <= 1'b0;
      pend_op_q      <= NOP;
      pend_end_q     <= 1'b0;
      in_ready_q     <= 1'b0;
      step_q         <= 1'b0;
      push_q         <= 1'b0;
      d_q            <= '0;
      op_q           <= NOP;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_q          <= '0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      pend_push_q    <= pend_push_d;
      pend_op_v_q    <= pend_op_v_d;
      pend_op_q      <= pend_op_d;
      pend_end_q     <= pend_end_d;
      in_ready_q     <= in_ready_d;
      step_q         <= step_d;
      push_q         <= push_d;
      d_q            <= d_d;
      op_q           <= op_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign step         = step_q;
  assign push         = push_q;
  assign d            = d_q;
  assign op           = op_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err          = err_q;

endmodule

// File: tb/tb_onp_tokenizer.sv
// Directed bench for onp_tokenizer with a small behavioural RPN core attached.
`timescale 1ns/1ps
module tb_onp_tokenizer;
  import onp_pkg::*;

  localparam int unsigned W     = 16;
  localparam int unsigned CNT_W = 10;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = '0;
  logic             in_ready, step, push, result_valid;
  logic [W-1:0]     d, result, top;
  logic [1:0]       op;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       err;

  int errors = 0;
  int checks = 0;

  onp_tokenizer #(.W(W), .CNT_W(CNT_W), .DEPTH(1024)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .step(step), .push(push), .d(d), .op(op),
    .cnt(cnt), .top(top), .result(result), .result_valid(result_valid),
    .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural core: executes on a rising step, seen on the clock.
  logic [W-1:0] stk [0:31];
  int           sp;
  logic         step_prev;
  assign cnt = CNT_W'(sp);
  assign top = (sp > 0) ? stk[sp-1] : '0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sp        <= 0;
      step_prev <= 1'b0;
    end else begin
      step_prev <= step;
      if (step && !step_prev) begin
        if (push) begin
          stk[sp] <= d;
          sp      <= sp + 1;
        end else begin
          case (op)
            2'd1: stk[sp-1] <= -stk[sp-1];
            2'd2: begin stk[sp-2] <= stk[sp-2] + stk[sp-1]; sp <= sp - 1; end
            2'd3: begin stk[sp-2] <= stk[sp-2] * stk[sp-1]; sp <= sp - 1; end
            default: ;
          endcase
        end
      end
    end
  end

  // Command log and result pulse counter.
  logic         log_push [$];
  logic [W-1:0] log_d [$];
  logic [1:0]   log_op [$];
  int           rv_count = 0;
  logic         step_seen = 1'b0;

  always @(negedge clk) begin
    if (step && !step_seen) begin
      log_push.push_back(push);
      log_d.push_back(d);
      log_op.push_back(op);
    end
    step_seen = step;
    if (result_valid) rv_count++;
  end

  task automatic do_reset();
    @(negedge clk);
    nrst     = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    log_push.delete();
    log_d.delete();
    log_op.delete();
    rv_count = 0;
    nrst     = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_char(input logic [7:0] c);
    int n;
    in_valid = 1'b1;
    in_data  = c;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL in_ready_timeout: char=%02h in_ready=%b required 1", c, in_ready);
    end
    checks++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run(input string s);
    int n;
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    n = 0;
    while (rv_count == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rv_count == 0) begin
      errors++;
      $display("FAIL result_timeout: \"%s\" result_valid pulses=0 required >=1", s);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    nrst = 1'b0;
    #1;
    checks++;
    if ({in_ready, step, push, result_valid, err, op} !== '0 || d !== '0 || result !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b step=%b push=%b rv=%b err=%b op=%0d d=%0d res=%0d required all 0",
               in_ready, step, push, result_valid, err, op, d, result);
    end
    do_reset();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_add();
    do_reset();
    run("12 34+=");
    checks++;
    if (log_push.size() !== 3) begin
      errors++; $display("FAIL add_steps: steps=%0d required 3", log_push.size());
    end else begin
      checks++;
      if (log_push[0] !== 1'b1 || log_d[0] !== 16'd12) begin
        errors++; $display("FAIL add_push0: push=%b d=%0d required 1/12", log_push[0], log_d[0]);
      end
      checks++;
      if (log_push[1] !== 1'b1 || log_d[1] !== 16'd34) begin
        errors++; $display("FAIL add_push1: push=%b d=%0d required 1/34", log_push[1], log_d[1]);
      end
      checks++;
      if (log_push[2] !== 1'b0 || log_op[2] !== 2'd2) begin
        errors++; $display("FAIL add_op: push=%b op=%0d required 0/2", log_push[2], log_op[2]);
      end
    end
    checks++;
    if (result !== 16'd46 || rv_count !== 1 || err !== 3'b000) begin
      errors++;
      $display("FAIL add_result: result=%0d pulses=%0d err=%b required 46/1/000", result, rv_count, err);
    end
  endtask

  task automatic test_mul_lf();
    do_reset();
    run("3 4*2+\n");
    checks++;
    if (result !== 16'd14 || err !== 3'b000 || log_push.size() !== 5) begin
      errors++;
      $display("FAIL mul_result: result=%0d err=%b steps=%0d required 14/000/5", result, err, log_push.size());
    end
  endtask

  task automatic test_negate();
    do_reset();
    run("5~=");
    checks++;
    if (result !== 16'hFFFB || err !== 3'b000) begin
      errors++; $display("FAIL neg_result: result=%h err=%b required fffb/000", result, err);
    end
    checks++;
    if (log_op.size() !== 2 || log_op[1] !== 2'd1) begin
      errors++; $display("FAIL neg_op: steps=%0d op=%0d required 2/1", log_op.size(), log_op[1]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run("70000=");
    checks++;
    if (log_d.size() !== 1 || log_d[0] !== 16'd4464) begin
      errors++; $display("FAIL wrap_push: steps=%0d d=%0d required 1/4464", log_d.size(), log_d[0]);
    end
    checks++;
    if (result !== 16'd4464 || err !== 3'b000) begin
      errors++; $display("FAIL wrap_result: result=%0d err=%b required 4464/000", result, err);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    run("+=");
    checks++;
    if (log_push.size() !== 0) begin
      errors++; $display("FAIL under_steps: steps=%0d required 0", log_push.size());
    end
    checks++;
    if (err !== 3'b010 || result !== 16'd0 || rv_count !== 1) begin
      errors++;
      $display("FAIL under_flags: err=%b result=%0d pulses=%0d required 010/0/1", err, result, rv_count);
    end
  endtask

  task automatic test_bad_char();
    do_reset();
    run("7a 1=");
    checks++;
    if (err !== 3'b001 || result !== 16'd1) begin
      errors++; $display("FAIL bad_char: err=%b result=%0d required 001/1", err, result);
    end
    checks++;
    if (log_d.size() !== 1 || log_d[0] !== 16'd1) begin
      errors++; $display("FAIL bad_discard: steps=%0d d=%0d required 1/1", log_d.size(), log_d[0]);
    end
  endtask

  task automatic test_reset_mid_cmd();
    int n;
    do_reset();
    send_char("9");
    send_char(" ");
    n = 0;
    while (!step && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!step) begin
      errors++; $display("FAIL strobe_timeout: step=%b required 1", step);
    end
    nrst = 1'b0;
    #1;
    checks++;
    if (step !== 1'b0 || dut.state_q !== S_IDLE || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: step=%b state=%0d rdy=%b required 0/%0d/0", step, dut.state_q, in_ready, S_IDLE);
    end
    do_reset();
    run("2=");
    checks++;
    if (result !== 16'd2 || err !== 3'b000 || rv_count !== 1) begin
      errors++;
      $display("FAIL after_abort: result=%0d err=%b pulses=%0d required 2/000/1", result, err, rv_count);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_lf();
    test_negate();
    test_wrap();
    test_underflow();
    test_bad_char();
    test_reset_mid_cmd();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
